// File: rtl/traffic_phase_ctrl_if.sv
// Sensor-side inputs and lamp-driver outputs of the intersection controller.
// master = the side driving sensors/reading lamps, slave = the controller.
interface traffic_phase_ctrl_if #(
    parameter int N_PHASE = 4
);
    localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

    logic [N_PHASE-1:0] car;
    logic               ped_button;
    logic [N_PHASE-1:0] red;
    logic [N_PHASE-1:0] yellow;
    logic [N_PHASE-1:0] green;
    logic               walk;
    logic               dont_walk;
    logic [PW-1:0]      phase_idx;
    logic               ped_pending;

    modport master (
        output car, ped_button,
        input  red, yellow, green, walk, dont_walk, phase_idx, ped_pending
    );

    modport slave (
        input  car, ped_button,
        output red, yellow, green, walk, dont_walk, phase_idx, ped_pending
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-approach round-robin signal controller with an exclusive pedestrian phase.
// All lamps are registered and derived from the next-state values.
module traffic_phase_ctrl #(
    parameter int N_PHASE   = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int PED_WALK  = 3,
    parameter int PED_CLEAR = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    traffic_phase_ctrl_if.slave bus
);
    localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam int M1 = (MAX_GREEN > YELLOW)   ? MAX_GREEN : YELLOW;
    localparam int M2 = (M1 > ALL_RED)         ? M1 : ALL_RED;
    localparam int M3 = (M2 > PED_WALK)        ? M2 : PED_WALK;
    localparam int MAXP = (M3 > PED_CLEAR)     ? M3 : PED_CLEAR;
    localparam int TW = $clog2(MAXP + 1);

    typedef enum logic [2:0] {
        S_GREEN, S_YELLOW, S_ALL_RED, S_PED_WALK, S_PED_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic               ped_q, ped_d;
    logic [N_PHASE-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic               walk_q, walk_d, dont_walk_q, dont_walk_d;

    logic               enter;
    logic               other;
    logic               found;
    logic [N_PHASE-1:0] own;
    logic [PW-1:0]      sel, cand;
    int                 shown;
    int                 idx;

    // Round-robin pick starting after the last-served phase, itself last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= N_PHASE; k++) begin
            idx = int'(phase_q) + k;
            if (idx >= N_PHASE) idx = idx - N_PHASE;
            cand = PW'(idx);
            if (!found && bus.car[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        enter   = 1'b0;
        own     = '0;
        own[phase_q] = 1'b1;
        other   = ped_q || ((bus.car & ~own) != '0);
        shown   = int'(timer_q) + 1;
        ped_d   = ped_q || (bus.ped_button && state_q != S_PED_WALK);

        case (state_q)
            S_GREEN: begin
                if (shown >= MIN_GREEN && other &&
                    (!bus.car[phase_q] || shown >= MAX_GREEN)) begin
                    state_d = S_YELLOW;
                    enter   = 1'b1;
                end
            end
            S_YELLOW: begin
                if (shown >= YELLOW) begin
                    state_d = S_ALL_RED;
                    enter   = 1'b1;
                end
            end
            S_ALL_RED: begin
                if (shown >= ALL_RED) begin
                    enter = 1'b1;
                    if (ped_q) begin
                        state_d = S_PED_WALK;
                    end else begin
                        state_d = S_GREEN;
                        phase_d = found ? sel : '0;
                    end
                end
            end
            S_PED_WALK: begin
                if (shown >= PED_WALK) begin
                    state_d = S_PED_CLEAR;
                    enter   = 1'b1;
                end
            end
            S_PED_CLEAR: begin
                if (shown >= PED_CLEAR) begin
                    state_d = S_ALL_RED;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_d = S_ALL_RED;
                enter   = 1'b1;
            end
        endcase

        // Clearing on walk entry wins over a press in the same cycle.
        if (enter && state_d == S_PED_WALK) ped_d = 1'b0;

        if (enter)          timer_d = '0;
        else if (&timer_q)  timer_d = timer_q;
        else                timer_d = timer_q + TW'(1);

        red_d       = '1;
        yellow_d    = '0;
        green_d     = '0;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        case (state_d)
            S_GREEN: begin
                green_d[phase_d] = 1'b1;
                red_d[phase_d]   = 1'b0;
            end
            S_YELLOW: begin
                yellow_d[phase_d] = 1'b1;
                red_d[phase_d]    = 1'b0;
            end
            S_PED_WALK: begin
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
            end
            S_PED_CLEAR: dont_walk_d = timer_d[0];
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_ALL_RED;
            timer_q     <= '0;
            phase_q     <= '0;
            ped_q       <= 1'b0;
            red_q       <= '1;
            yellow_q    <= '0;
            green_q     <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            ped_q       <= ped_d;
            red_q       <= red_d;
            yellow_q    <= yellow_d;
            green_q     <= green_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
        end
    end

    assign bus.red         = red_q;
    assign bus.yellow      = yellow_q;
    assign bus.green       = green_q;
    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.phase_idx   = phase_q;
    assign bus.ped_pending = ped_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl at default parameters.
module tb_traffic_phase_ctrl;
    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    traffic_phase_ctrl_if #(.N_PHASE(4)) bus ();

    traffic_phase_ctrl #(
        .N_PHASE(4), .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW(2),
        .ALL_RED(1), .PED_WALK(3), .PED_CLEAR(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: got %0h want %0h", tag, fld, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the visible lamp state, then advance one cycle; repeated n times.
    task automatic hold(input string tag, input logic [3:0] r, input logic [3:0] y,
                        input logic [3:0] g, input logic w, input logic dw, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, "red",       32'(bus.red),       32'(r));
            chk(tag, "yellow",    32'(bus.yellow),    32'(y));
            chk(tag, "green",     32'(bus.green),     32'(g));
            chk(tag, "walk",      32'(bus.walk),      32'(w));
            chk(tag, "dont_walk", 32'(bus.dont_walk), 32'(dw));
            tick();
        end
    endtask

    task automatic reset_pulse(input string tag);
        reset_n = 1'b0;
        #1;
        chk(tag, "red",       32'(bus.red),         32'hF);
        chk(tag, "yellow",    32'(bus.yellow),      32'h0);
        chk(tag, "green",     32'(bus.green),       32'h0);
        chk(tag, "walk",      32'(bus.walk),        32'h0);
        chk(tag, "dont_walk", 32'(bus.dont_walk),   32'h1);
        chk(tag, "phase_idx", 32'(bus.phase_idx),   32'h0);
        chk(tag, "ped_pend",  32'(bus.ped_pending), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.car        = 4'b0000;
        bus.ped_button = 1'b0;
        reset_n        = 1'b0;
        tick();
        reset_pulse("reset");

        // Rest in phase 0 with no demand.
        hold("rst_ar", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("rest",   4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 50);

        // Gap-out of phase 0 to demand on phase 2.
        reset_pulse("reset2");
        hold("ar0", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.car = 4'b0100;
        hold("g0_gap", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 4);
        hold("y0_gap", 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_gap", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        chk("sel2", "phase_idx", 32'(bus.phase_idx), 32'd2);

        // Move back to phase 0, then max-out both 0 and 1 and wrap.
        bus.car = 4'b0001;
        hold("g2",   4'b1011, 4'b0000, 4'b0100, 1'b0, 1'b1, 4);
        hold("y2",   4'b1011, 4'b0100, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar2",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.car = 4'b0011;
        hold("g0_max", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 10);
        hold("y0_max", 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_max", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        chk("sel1", "phase_idx", 32'(bus.phase_idx), 32'd1);
        hold("g1_max", 4'b1101, 4'b0000, 4'b0010, 1'b0, 1'b1, 10);
        hold("y1_max", 4'b1101, 4'b0010, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_wrap", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        chk("wrap0", "phase_idx", 32'(bus.phase_idx), 32'd0);

        // Gap to phase 1, then a single-cycle pedestrian press.
        bus.car = 4'b0010;
        hold("g0_b",  4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 4);
        hold("y0_b",  4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_b",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.car = 4'b0000;
        bus.ped_button = 1'b1;
        hold("g1_ped", 4'b1101, 4'b0000, 4'b0010, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b0;
        chk("ped_set", "ped_pend", 32'(bus.ped_pending), 32'h1);
        hold("g1_ped", 4'b1101, 4'b0000, 4'b0010, 1'b0, 1'b1, 3);
        hold("y1_ped", 4'b1101, 4'b0010, 4'b0000, 1'b0, 1'b1, 2);
        chk("ped_ar", "ped_pend", 32'(bus.ped_pending), 32'h1);
        hold("ar_ped", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        chk("walk_in", "ped_pend", 32'(bus.ped_pending), 32'h0);
        hold("walk",  4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3);
        hold("clr0",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr1",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("clr2",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr3",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("ar_pc", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        chk("rest_pc", "phase_idx", 32'(bus.phase_idx), 32'd0);

        // Press during walk is ignored: walk once, then back to rest.
        bus.ped_button = 1'b1;
        hold("g0_pa", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b0;
        hold("g0_pa", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 3);
        hold("y0_pa", 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_pa", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b1;
        hold("walk_pa", 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1);
        bus.ped_button = 1'b0;
        chk("walk_ign", "ped_pend", 32'(bus.ped_pending), 32'h0);
        hold("walk_pa", 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 2);
        hold("clr_pa0", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr_pa1", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("clr_pa2", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr_pa3", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("ar_pa2",  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("g0_noped", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);

        // Press during clear gives a second full walk; press held on the
        // walk-entry cycle still leaves ped_pending cleared.
        bus.ped_button = 1'b1;
        hold("g0_pb", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b0;
        hold("g0_pb", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 2);
        hold("y0_pb", 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_pb", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("walk_pb", 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3);
        hold("clr_pb0", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        bus.ped_button = 1'b1;
        hold("clr_pb1", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b0;
        chk("clr_set", "ped_pend", 32'(bus.ped_pending), 32'h1);
        hold("clr_pb2", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr_pb3", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b1;
        hold("ar_pb2", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        bus.ped_button = 1'b0;
        chk("setclr", "ped_pend", 32'(bus.ped_pending), 32'h0);
        hold("walk2",  4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3);
        hold("clr2_0", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr2_1", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("clr2_2", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
        hold("clr2_3", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("ar_pb3", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);

        // Serve phase 3, then reset in the middle of its yellow.
        bus.car = 4'b1000;
        hold("g0_c", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 4);
        hold("y0_c", 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1, 2);
        hold("ar_c", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        chk("sel3", "phase_idx", 32'(bus.phase_idx), 32'd3);
        bus.car = 4'b0001;
        hold("g3", 4'b0111, 4'b0000, 4'b1000, 1'b0, 1'b1, 4);
        hold("y3", 4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b1, 1);
        chk("y3_mid", "yellow", 32'(bus.yellow), 32'h8);
        reset_pulse("reset_mid");
        hold("ar_mid", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1);
        hold("g0_mid", 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);
        chk("mid_idx", "phase_idx", 32'(bus.phase_idx), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
